// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: datapath widths, the bubble word and the fetch FSM encoding.
package mips_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Instruction fetches are word aligned; the two low address bits are dropped.
  function automatic logic [WORD_W-1:0] alignPc(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush to a bubble, hold, or load a freshly fetched word.
module if_id_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [WORD_W-1:0] instrIn,
  input  logic [WORD_W-1:0] pc4In,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc4,
  output logic              valid
);

  // Flush wins over hold so a redirect during a stall still kills the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= instrIn;
      pc4   <= pc4In;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, boot/run/halt sequencing, fetch counter and IF/ID register.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   BOOT   | one settling cycle after reset; PC held, IF/ID stays a bubble
//   RUN    | fetching: advance, stall or redirect each cycle
//   HALTED | fetch stopped until reset; IF/ID is flushed every cycle
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count,
  output logic        halted
);

  fetch_state_t state, stateNext;

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pcNext;
  logic [WORD_W-1:0] pcPlus4;
  logic [WORD_W-1:0] fetchCount;
  logic              countInc;
  logic              ifidHold;
  logic              ifidFlush;

  assign pcPlus4   = pc + WORD_W'(INSTR_BYTES);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      BOOT:    stateNext = RUN;
      RUN:     if (halt_req) stateNext = HALTED;
      HALTED:  stateNext = HALTED;
      default: stateNext = BOOT;
    endcase
  end

  // Redirect outranks stall; the halting cycle still performs its normal RUN action.
  always_comb begin
    pcNext    = pc;
    countInc  = 1'b0;
    ifidHold  = 1'b1;
    ifidFlush = 1'b0;
    halted    = 1'b0;
    unique case (state)
      RUN: begin
        if (redirect_valid) begin
          pcNext    = alignPc(redirect_pc);
          ifidFlush = 1'b1;
        end else if (!stall) begin
          pcNext   = pcPlus4;
          countInc = 1'b1;
          ifidHold = 1'b0;
        end
      end
      HALTED: begin
        ifidFlush = 1'b1;
        halted    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= alignPc(RESET_PC);
      fetchCount <= '0;
    end else begin
      pc <= pcNext;
      if (countInc) fetchCount <= fetchCount + 32'd1;
    end
  end

  assign fetch_count = fetchCount;

  if_id_reg uIfIdReg (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (ifidHold),
    .flush   (ifidFlush),
    .instrIn (imem_instr),
    .pc4In   (pcPlus4),
    .instr   (ifid_instr),
    .pc4     (ifid_pc4),
    .valid   (ifid_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/stall/redirect/halt/reset/wrap cases, then randomized traffic.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic        halted;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model state
  logic [31:0] mPc, mInstr, mPc4, mCount;
  logic        mValid, mBooted, mHalted;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_instr = memWord(imem_addr);

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .ifid_valid     (ifid_valid),
    .fetch_count    (fetch_count),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".addr"},   imem_addr,          mPc);
    check({tag, ".instr"},  ifid_instr,         mInstr);
    check({tag, ".pc4"},    ifid_pc4,           mPc4);
    check({tag, ".valid"},  32'(ifid_valid),    32'(mValid));
    check({tag, ".count"},  fetch_count,        mCount);
    check({tag, ".halted"}, 32'(halted),        32'(mHalted));
  endtask

  task automatic modelReset();
    mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
    mCount = 32'h0; mBooted = 1'b0; mHalted = 1'b0;
  endtask

  task automatic modelEdge(input logic s, input logic r, input logic [31:0] rpc, input logic h);
    if (!mBooted) begin
      mBooted = 1'b1;
    end else if (mHalted) begin
      mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
    end else begin
      if (r) begin
        mPc = rpc & 32'hFFFF_FFFC;
        mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      end else if (!s) begin
        mInstr = memWord(mPc);
        mPc4 = mPc + 32'd4;
        mValid = 1'b1;
        mPc = mPc + 32'd4;
        mCount = mCount + 32'd1;
      end
      if (h) mHalted = 1'b1;
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic h,
                      input string tag);
    stall = s; redirect_valid = r; redirect_pc = rpc; halt_req = h;
    @(posedge clk);
    modelEdge(s, r, rpc, h);
    #1;
    checkAll(tag);
  endtask

  // Assert reset away from the edge; outputs must clear before the next edge.
  task automatic resetMid(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #1 rst_n = 1'b0;
    #2 checkAll("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Boot then fetch 0 and 4
    check("boot_addr0", imem_addr, 32'h0);
    step(1'b1, 1'b1, 32'h80, 1'b1, "boot");
    check("boot_addr1", imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, "fetch0");
    check("fetch0_word", ifid_instr, memWord(32'h0));
    step(1'b0, 1'b0, 32'h0, 1'b0, "fetch4");
    check("fetch4_pc4", ifid_pc4, 32'h8);

    // Stall three cycles at PC=8
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, "stall");
    check("stall_addr", imem_addr, 32'h8);
    check("stall_count", fetch_count, 32'd2);
    step(1'b0, 1'b0, 32'h0, 1'b0, "fetch8");
    check("fetch8_word", ifid_instr, memWord(32'h8));
    check("fetch8_count", fetch_count, 32'd3);

    // Halt at PC=12
    step(1'b0, 1'b0, 32'h0, 1'b1, "halt");
    check("halt_word", ifid_instr, memWord(32'hC));
    check("halt_flag", 32'(halted), 32'd1);
    step(1'b0, 1'b1, 32'h40, 1'b0, "halted_redir");
    check("halted_addr", imem_addr, 32'h10);
    check("halted_valid", 32'(ifid_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, "halted_idle");

    // Redirect under stall, then misaligned target
    resetMid("rst1");
    step(1'b0, 1'b0, 32'h0, 1'b0, "boot2");
    step(1'b0, 1'b0, 32'h0, 1'b0, "fetchA");
    step(1'b1, 1'b1, 32'h20, 1'b0, "redir_stall");
    check("redir_addr", imem_addr, 32'h20);
    check("redir_bubble", ifid_instr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, "fetch20");
    check("fetch20_word", ifid_instr, memWord(32'h20));
    step(1'b0, 1'b1, 32'h37, 1'b0, "redir37");
    check("redir37_addr", imem_addr, 32'h34);

    // Reset mid-cycle while a redirect is pending
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    resetMid("rst_redir");

    // PC wrap
    step(1'b0, 1'b0, 32'h0, 1'b0, "boot3");
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, "redir_top");
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0, "fetch_top");
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc4", ifid_pc4, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, "fetch_wrap");
    check("wrap_word", ifid_instr, memWord(32'h0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0 || (mHalted && $urandom_range(0, 15) == 0)) begin
        stall = 1'($urandom_range(0, 1));
        redirect_valid = 1'($urandom_range(0, 1));
        redirect_pc = $urandom;
        resetMid("rnd_rst");
      end else begin
        step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 2), $urandom,
             1'($urandom_range(0, 79) == 0), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-004 SHALL have port stall  input  1  meaning hold PC and IF/ID (from hazard unit).
REQ-005 SHALL have port redirect_valid  input  1  meaning the branch is taken and the fetch is redirected.
REQ-006 SHALL have port redirect_pc  input  32  meaning the branch target byte address.
REQ-007 SHALL have port halt_req  input  1  meaning stop fetching until reset.
REQ-008 SHALL have port imem_addr  output  32  meaning the byte address to instruction memory.
REQ-009 SHALL have port imem_instr  input  32  meaning the combinational instruction word read at imem_addr.
REQ-010 SHALL have port ifid_instr  output  32  meaning the registered instruction for decode.
REQ-011 SHALL have port ifid_pc4  output  32  meaning the registered fetch address + 4.
REQ-012 SHALL have port ifid_valid  output  1  meaning ifid_instr holds a real instruction, not a bubble.
REQ-013 SHALL have port fetch_count  output  32  meaning the number of instructions captured into IF/ID.
REQ-014 SHALL have port halted  output  1  meaning the FSM is in HALTED.

Function
REQ-015 SHALL drive imem_addr combinationally from the PC register; PC[1:0] always 0.
REQ-016 SHALL implement FSM states BOOT, RUN, HALTED; reset enters BOOT.
REQ-017 SHALL spend exactly one cycle in BOOT (PC held, ifid_valid 0), then go to RUN.
REQ-018 SHALL, in RUN with stall=0 and redirect_valid=0, load PC <= PC+4 and IF/ID <= {imem_instr, PC+4, valid=1}, and increment fetch_count.
REQ-019 SHALL give one-cycle latency: the word at address A appears on ifid_instr after the edge at which imem_addr=A was sampled.
REQ-020 SHALL, in RUN with stall=1 and redirect_valid=0, hold PC, IF/ID and fetch_count unchanged.
REQ-021 SHALL, in RUN with redirect_valid=1, load PC <= {redirect_pc[31:2],2'b00}, load IF/ID <= {32'h0, 32'h0, valid=0}, and leave fetch_count unchanged; redirect overrides stall.
REQ-022 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0); fetch_count wraps at 2^32.
REQ-023 SHALL, on halt_req=1 in RUN, perform the normal action of REQ-018/020/021 for that cycle, then enter HALTED.
REQ-024 SHALL, in HALTED, hold PC and fetch_count, force ifid_valid 0 and ignore stall, redirect_valid and halt_req; only reset exits.
REQ-025 SHALL ignore stall, redirect_valid and halt_req while in BOOT.
REQ-026 SHALL assert halted exactly while the FSM is in HALTED.

Reset
REQ-027 SHALL, on rst_n=0 at any time, including mid-stall or mid-redirect, immediately set PC=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fetch_count=0, halted=0, and state=BOOT.
REQ-028 SHALL resume at the first rising clk edge after rst_n rises, starting the BOOT cycle.

Structure
REQ-029 SHALL take WORD_W=32, INSTR_BYTES=4, the NOP word 32'h0 and the fetch_state_t enum (BOOT, RUN, HALTED) from shared package mips_pkg.
REQ-030 SHALL place the IF/ID register (hold/flush/load, async-reset) in sub-module if_id_reg; PC, FSM and counter stay in if_stage.

Verification
REQ-031 SHALL cover reset release with RESET_PC=0 and a program at 0,4,8 -> imem_addr 0 for two cycles (BOOT), then ifid_instr equals the words at 0, 4, 8 on consecutive cycles with ifid_pc4 4, 8, 12 and fetch_count 1, 2, 3.
REQ-032 SHALL cover stall=1 for 3 cycles at PC=8 -> imem_addr stays 8, IF/ID unchanged, fetch_count unchanged, and fetching resumes at 8 when stall drops.
REQ-033 SHALL cover redirect_valid=1 with redirect_pc=32'h20 while stall=1 -> next cycle imem_addr=32'h20, ifid_valid=0, ifid_instr=0; the following cycle captures the word at 32'h20.
REQ-034 SHALL cover redirect_pc=32'h37 -> imem_addr=32'h34.
REQ-035 SHALL cover halt_req pulsed at PC=12 -> the word at 12 is captured, halted=1 next cycle, imem_addr stays 16, ifid_valid=0, and a later redirect is ignored.
REQ-036 SHALL cover rst_n=0 asserted mid-cycle during a redirect and PC=32'hFFFF_FFFC wrap -> outputs reach reset values before the next edge, and the wrap case fetches address 0 after FFFF_FFFC.
